// File: rtl/ram_dp_be.sv
// Dual-port RAM: read-only fetch port plus byte-strobed data port, with registered outputs
// (latency 1 or 2), write-first forwarding into the fetch port and a data-port error flag.
`ifndef MEM_READ
`define MEM_READ 1'b0
`endif
`ifndef MEM_WRITE
`define MEM_WRITE 1'b1
`endif

module ram_dp_be #(
    parameter int    DATA_WIDTH   = 32,
    parameter int    ADDR_WIDTH   = 32,
    parameter int    DEPTH        = 16384,
    parameter int    READ_LATENCY = 1,
    parameter string INIT_FILE    = "../testbench/build/firmware.hex"
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    if_ena,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic [DATA_WIDTH-1:0]   if_data,
    output logic                    if_valid,
    input  logic                    mem_ena,
    input  logic                    mem_rw,
    input  logic [ADDR_WIDTH-1:0]   mem_addr,
    input  logic [DATA_WIDTH/8-1:0] mem_wstrb,
    input  logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    mem_valid,
    output logic                    mem_err
);

    localparam int NB       = DATA_WIDTH / 8;
    localparam int LSB      = $clog2(NB);
    localparam int IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int HI_SHIFT = LSB + IDX_W;
    localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'((1 << LSB) - 1);

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
        return a[LSB +: IDX_W];
    endfunction

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return (int'(word_idx(a)) < DEPTH) && ((a >> HI_SHIFT) == '0);
    endfunction

    logic [IDX_W-1:0] if_idx, mem_idx;
    logic             if_rd, mem_rd, mem_wr, mem_bad, fwd_hit;

    assign if_idx  = word_idx(if_addr);
    assign mem_idx = word_idx(mem_addr);
    assign if_rd   = if_ena && in_range(if_addr);
    assign mem_bad = mem_ena && (((mem_addr & LOW_MASK) != '0) || !in_range(mem_addr));
    assign mem_wr  = mem_ena && !mem_bad && (mem_rw == `MEM_WRITE);
    assign mem_rd  = mem_ena && !mem_bad && (mem_rw == `MEM_READ);
    assign fwd_hit = if_rd && mem_wr && (if_idx == mem_idx);

    // Block RAM: no reset, read registers only load on a real read so outputs can hold.
    logic [DATA_WIDTH-1:0] ram [DEPTH];
    logic [DATA_WIDTH-1:0] if_bram_rd, mem_bram_rd;

    always_ff @(posedge clk) begin
        if (mem_wr) begin
            for (int b = 0; b < NB; b++) begin
                if (mem_wstrb[b]) ram[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
        if (if_rd)  if_bram_rd  <= ram[if_idx];
        if (mem_rd) mem_bram_rd <= ram[mem_idx];
    end

    logic                  if_v1_q, if_v1_d;
    logic                  if_zero1_q, if_zero1_d;
    logic                  if_fwd1_q, if_fwd1_d;
    logic [NB-1:0]         if_fwd_strb1_q, if_fwd_strb1_d;
    logic [DATA_WIDTH-1:0] if_fwd_data1_q, if_fwd_data1_d;
    logic                  mem_v1_q, mem_v1_d;
    logic                  mem_err1_q, mem_err1_d;
    logic                  mem_zero1_q, mem_zero1_d;

    always_comb begin
        if_v1_d        = if_ena;
        if_zero1_d     = if_zero1_q;
        if_fwd1_d      = if_fwd1_q;
        if_fwd_strb1_d = if_fwd_strb1_q;
        if_fwd_data1_d = if_fwd_data1_q;
        mem_v1_d       = mem_ena;
        mem_err1_d     = mem_bad;
        mem_zero1_d    = mem_zero1_q;
        if (if_ena) begin
            if_zero1_d     = !if_rd;
            if_fwd1_d      = fwd_hit;
            if_fwd_strb1_d = mem_wstrb;
            if_fwd_data1_d = mem_wdata;
        end
        if (mem_ena) mem_zero1_d = !mem_rd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_v1_q        <= 1'b0;
            if_zero1_q     <= 1'b1;
            if_fwd1_q      <= 1'b0;
            if_fwd_strb1_q <= '0;
            if_fwd_data1_q <= '0;
            mem_v1_q       <= 1'b0;
            mem_err1_q     <= 1'b0;
            mem_zero1_q    <= 1'b1;
        end else begin
            if_v1_q        <= if_v1_d;
            if_zero1_q     <= if_zero1_d;
            if_fwd1_q      <= if_fwd1_d;
            if_fwd_strb1_q <= if_fwd_strb1_d;
            if_fwd_data1_q <= if_fwd_data1_d;
            mem_v1_q       <= mem_v1_d;
            mem_err1_q     <= mem_err1_d;
            mem_zero1_q    <= mem_zero1_d;
        end
    end

    // The RAM read returns the pre-write word, so forwarded bytes are merged on top of it.
    logic [DATA_WIDTH-1:0] if_word1, mem_word1;

    always_comb begin
        if_word1 = if_bram_rd;
        if (if_fwd1_q) begin
            for (int b = 0; b < NB; b++) begin
                if (if_fwd_strb1_q[b]) if_word1[8*b +: 8] = if_fwd_data1_q[8*b +: 8];
            end
        end
        if (if_zero1_q) if_word1 = '0;
        mem_word1 = mem_zero1_q ? '0 : mem_bram_rd;
    end

    if (READ_LATENCY == 1) begin : g_lat1
        assign if_data   = if_word1;
        assign if_valid  = if_v1_q;
        assign mem_rdata = mem_word1;
        assign mem_valid = mem_v1_q;
        assign mem_err   = mem_err1_q;
    end else if (READ_LATENCY == 2) begin : g_lat2
        logic                  if_v2_q, if_v2_d;
        logic [DATA_WIDTH-1:0] if_data2_q, if_data2_d;
        logic                  mem_v2_q, mem_v2_d;
        logic                  mem_err2_q, mem_err2_d;
        logic [DATA_WIDTH-1:0] mem_data2_q, mem_data2_d;

        always_comb begin
            if_v2_d     = if_v1_q;
            if_data2_d  = if_v1_q ? if_word1 : if_data2_q;
            mem_v2_d    = mem_v1_q;
            mem_err2_d  = mem_err1_q;
            mem_data2_d = mem_v1_q ? mem_word1 : mem_data2_q;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                if_v2_q     <= 1'b0;
                if_data2_q  <= '0;
                mem_v2_q    <= 1'b0;
                mem_err2_q  <= 1'b0;
                mem_data2_q <= '0;
            end else begin
                if_v2_q     <= if_v2_d;
                if_data2_q  <= if_data2_d;
                mem_v2_q    <= mem_v2_d;
                mem_err2_q  <= mem_err2_d;
                mem_data2_q <= mem_data2_d;
            end
        end

        assign if_data   = if_data2_q;
        assign if_valid  = if_v2_q;
        assign mem_rdata = mem_data2_q;
        assign mem_valid = mem_v2_q;
        assign mem_err   = mem_err2_q;
    end else begin : g_bad_latency
        $error("ram_dp_be: READ_LATENCY must be 1 or 2");
    end

endmodule

// File: tb/tb_ram_dp_be.sv
// Bench for ram_dp_be: latency-1 and latency-2 instances share stimulus and are checked
// against a word-array model of the memory plus expected-output registers per latency.
module tb_ram_dp_be;

    localparam int AW    = 16;
    localparam int DW    = 32;
    localparam int DEPTH = 80;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          if_ena = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          mem_ena = 1'b0;
    logic          mem_rw = 1'b0;
    logic [AW-1:0] mem_addr = '0;
    logic [3:0]    mem_wstrb = '0;
    logic [DW-1:0] mem_wdata = '0;

    logic [DW-1:0] d1_if_data, d1_mem_rdata, d2_if_data, d2_mem_rdata;
    logic          d1_if_valid, d1_mem_valid, d1_mem_err;
    logic          d2_if_valid, d2_mem_valid, d2_mem_err;

    always #5 clk = ~clk;

    ram_dp_be #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .READ_LATENCY(1), .INIT_FILE("")) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .if_ena(if_ena), .if_addr(if_addr), .if_data(d1_if_data), .if_valid(d1_if_valid),
        .mem_ena(mem_ena), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
        .mem_wdata(mem_wdata), .mem_rdata(d1_mem_rdata), .mem_valid(d1_mem_valid), .mem_err(d1_mem_err)
    );

    ram_dp_be #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .READ_LATENCY(2), .INIT_FILE("")) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .if_ena(if_ena), .if_addr(if_addr), .if_data(d2_if_data), .if_valid(d2_if_valid),
        .mem_ena(mem_ena), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
        .mem_wdata(mem_wdata), .mem_rdata(d2_mem_rdata), .mem_valid(d2_mem_valid), .mem_err(d2_mem_err)
    );

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] model [DEPTH];

    // Expected outputs: e1_* for latency 1, e2_* for latency 2, p_* is last edge's response.
    logic          e1_if_v, e1_mem_v, e1_mem_e, e2_if_v, e2_mem_v, e2_mem_e, p_if_v, p_mem_v, p_mem_e;
    logic [DW-1:0] e1_if_d, e1_mem_d, e2_if_d, e2_mem_d, p_if_d, p_mem_d;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("l1_if_valid",  DW'(d1_if_valid),  DW'(e1_if_v));
        check("l1_if_data",   d1_if_data,        e1_if_d);
        check("l1_mem_valid", DW'(d1_mem_valid), DW'(e1_mem_v));
        check("l1_mem_err",   DW'(d1_mem_err),   DW'(e1_mem_e));
        check("l1_mem_rdata", d1_mem_rdata,      e1_mem_d);
        check("l2_if_valid",  DW'(d2_if_valid),  DW'(e2_if_v));
        check("l2_if_data",   d2_if_data,        e2_if_d);
        check("l2_mem_valid", DW'(d2_mem_valid), DW'(e2_mem_v));
        check("l2_mem_err",   DW'(d2_mem_err),   DW'(e2_mem_e));
        check("l2_mem_rdata", d2_mem_rdata,      e2_mem_d);
    endtask

    task automatic clear_expect();
        {e1_if_v, e1_mem_v, e1_mem_e, e2_if_v, e2_mem_v, e2_mem_e, p_if_v, p_mem_v, p_mem_e} = '0;
        {e1_if_d, e1_mem_d, e2_if_d, e2_mem_d, p_if_d, p_mem_d} = '0;
    endtask

    function automatic bit in_rng(input logic [AW-1:0] a);
        return int'(a >> 2) < DEPTH;
    endfunction

    task automatic idle();
        if_ena = 1'b0; mem_ena = 1'b0; mem_rw = 1'b0; mem_wstrb = '0;
    endtask

    task automatic set_if(input logic [AW-1:0] a);
        if_ena = 1'b1; if_addr = a;
    endtask

    task automatic set_mem(input logic rw, input logic [AW-1:0] a, input logic [3:0] s, input logic [DW-1:0] d);
        mem_ena = 1'b1; mem_rw = rw; mem_addr = a; mem_wstrb = s; mem_wdata = d;
    endtask

    // Apply current inputs for one clock: model the access at the edge, then check all outputs.
    task automatic step();
        logic          r_if_v, r_mem_v, r_mem_e;
        logic [DW-1:0] r_if_d, r_mem_d;
        int            wi;
        r_mem_v = mem_ena;
        r_mem_e = mem_ena && ((mem_addr[1:0] != 2'b00) || !in_rng(mem_addr));
        r_mem_d = '0;
        if (mem_ena && !r_mem_e) begin
            wi = int'(mem_addr >> 2);
            if (mem_rw) begin
                for (int b = 0; b < 4; b++)
                    if (mem_wstrb[b]) model[wi][8*b +: 8] = mem_wdata[8*b +: 8];
            end else begin
                r_mem_d = model[wi];
            end
        end
        r_if_v = if_ena;
        r_if_d = in_rng(if_addr) ? model[int'(if_addr >> 2)] : '0;
        @(posedge clk);
        #1;
        e1_if_v = r_if_v;
        if (r_if_v) e1_if_d = r_if_d;
        e1_mem_v = r_mem_v;
        e1_mem_e = r_mem_e;
        if (r_mem_v) e1_mem_d = r_mem_d;
        e2_if_v = p_if_v;
        if (p_if_v) e2_if_d = p_if_d;
        e2_mem_v = p_mem_v;
        e2_mem_e = p_mem_e;
        if (p_mem_v) e2_mem_d = p_mem_d;
        p_if_v = r_if_v;  p_if_d = r_if_d;
        p_mem_v = r_mem_v; p_mem_e = r_mem_e; p_mem_d = r_mem_d;
        check_all();
    endtask

    initial begin
        logic [DW-1:0] w;
        clear_expect();
        idle();
        #2;
        check_all();
        #20 rst_n = 1'b1;
        step(); step();

        // Preload every word through the data port.
        for (int i = 0; i < DEPTH; i++) begin
            w = $urandom;
            if (i == 16'h10) w = 32'hDEADBEEF;
            if (i == 16'h40) w = 32'h12345678;
            set_mem(1'b1, AW'(i * 4), 4'hF, w);
            step();
        end
        idle(); step();

        // Single fetch, then hold.
        set_if(16'h0040); step();
        check("fetch_l1_data", d1_if_data, 32'hDEADBEEF);
        check("fetch_l1_valid", DW'(d1_if_valid), 32'd1);
        idle(); step();
        check("fetch_l1_hold_valid", DW'(d1_if_valid), 32'd0);
        check("fetch_l1_hold_data", d1_if_data, 32'hDEADBEEF);
        check("fetch_l2_data", d2_if_data, 32'hDEADBEEF);

        // Byte-strobe merge.
        set_mem(1'b1, 16'h0080, 4'b1111, 32'h11223344); step();
        set_mem(1'b1, 16'h0080, 4'b0101, 32'hAABBCCDD); step();
        set_mem(1'b0, 16'h0080, 4'b0000, 32'h0); step();
        check("rmw_l1", d1_mem_rdata, 32'h11BB33DD);
        idle(); step();
        check("rmw_l2", d2_mem_rdata, 32'h11BB33DD);

        // Same-cycle write and fetch of one word: write-first.
        set_mem(1'b1, 16'h0100, 4'b0011, 32'hCAFEF00D);
        set_if(16'h0100); step();
        check("fwd_l1", d1_if_data, 32'h1234F00D);
        idle(); step();
        check("fwd_l2", d2_if_data, 32'h1234F00D);

        // Error cases leave memory untouched.
        set_mem(1'b0, 16'h0000, 4'h0, 32'h0); step();
        set_mem(1'b0, 16'h0102, 4'h0, 32'h0); step();
        check("misaligned_err", DW'(d1_mem_err), 32'd1);
        set_mem(1'b1, AW'(DEPTH * 4), 4'hF, 32'hFFFFFFFF); step();
        check("oor_write_err", DW'(d1_mem_err), 32'd1);
        check("oor_write_rdata", d1_mem_rdata, 32'h0);
        set_mem(1'b1, 16'h8000, 4'hF, 32'hFFFFFFFF); step();
        set_if(AW'(DEPTH * 4));
        set_mem(1'b0, 16'h0000, 4'h0, 32'h0); step();
        check("oor_fetch_zero", d1_if_data, 32'h0);
        idle(); step();

        // Back-to-back reads on both ports.
        for (int i = 0; i < 3; i++) begin
            set_if(AW'(i * 4));
            set_mem(1'b0, AW'(i * 4), 4'h0, 32'h0);
            step();
        end
        idle(); step(); step();

        // Asynchronous reset mid-cycle with requests in flight.
        set_if(16'h0040); set_mem(1'b0, 16'h0080, 4'h0, 32'h0); step();
        set_if(16'h0044); set_mem(1'b0, 16'h0084, 4'h0, 32'h0); step();
        #3 rst_n = 1'b0;
        #1;
        clear_expect();
        check_all();
        idle();
        @(posedge clk); @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        step(); step(); step();
        set_mem(1'b0, 16'h0040, 4'h0, 32'h0); step();
        check("post_reset_read", d1_mem_rdata, 32'hDEADBEEF);
        idle(); step();

        // Random traffic.
        for (int n = 0; n < 500; n++) begin
            if_ena    = ($urandom_range(0, 3) != 0);
            if_addr   = ($urandom_range(0, 9) == 0) ? AW'($urandom) : AW'($urandom_range(0, DEPTH * 4 + 15));
            mem_ena   = ($urandom_range(0, 3) != 0);
            mem_rw    = 1'($urandom_range(0, 1));
            mem_wstrb = 4'($urandom_range(0, 15));
            mem_wdata = $urandom;
            case ($urandom_range(0, 9))
                0:       mem_addr = AW'($urandom);
                1:       mem_addr = AW'($urandom_range(0, DEPTH * 4 + 15));
                default: mem_addr = AW'($urandom_range(0, DEPTH + 3) * 4);
            endcase
            if ($urandom_range(0, 3) == 0) if_addr = mem_addr;
            step();
        end
        idle(); step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
